// File: rtl/uart_rx_top.sv
// uart_rx_top: 16x oversampling UART receiver with parity/framing/break status; UART_RX_SYNC_EN adds a two-flop rx synchronizer
module uart_rx_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       pen,
  input  logic [1:0] wls,
  output logic [7:0] rx_data,
  output logic       push,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       rx_busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic [1:0] wls_l, wls_l_n;
  logic       pbit, pbit_n, pen_l, pen_l_n, eps_l, eps_l_n, sp_l, sp_l_n;
  logic       rxs, done, exp_par;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  // two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge clk)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx};
  assign rxs = sync[1];
`else
  assign rxs = rx;
`endif
  assign done    = baud_pulse && state == STOP && cnt == 4'd15;
  assign exp_par = sp_l ? ~eps_l : (eps_l ? ^shreg : ~^shreg);
  assign rx_busy = state != IDLE;
  // next-state and datapath updates, advancing only on baud ticks
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    pbit_n  = pbit;
    wls_l_n = wls_l;
    pen_l_n = pen_l;
    eps_l_n = eps_l;
    sp_l_n  = sp_l;
    if (baud_pulse)
      case (state)
        IDLE: if (!rxs) begin
          state_n = START;
          cnt_n   = 4'd0;
        end
        START: if (cnt == 4'd7) begin
          state_n = rxs ? IDLE : DATA;
          if (!rxs) begin
            wls_l_n = wls;
            pen_l_n = pen;
            eps_l_n = eps;
            sp_l_n  = sticky_parity;
            cnt_n   = 4'd0;
            idx_n   = 3'd0;
            shreg_n = 8'd0;
            pbit_n  = 1'b0;
          end
        end else cnt_n = cnt + 4'd1;
        DATA: begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            shreg_n[idx] = rxs;
            idx_n = idx + 3'd1;
            if (idx == {1'b1, wls_l}) state_n = pen_l ? PARITY : STOP;
          end
        end
        PARITY: begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            pbit_n  = rxs;
            state_n = STOP;
          end
        end
        STOP: begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) state_n = rxs ? IDLE : BRK_WAIT;
        end
        BRK_WAIT: if (rxs) state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  // state and datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      idx   <= 3'd0;
      shreg <= 8'd0;
      pbit  <= 1'b0;
      wls_l <= 2'd0;
      pen_l <= 1'b0;
      eps_l <= 1'b0;
      sp_l  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      pbit  <= pbit_n;
      wls_l <= wls_l_n;
      pen_l <= pen_l_n;
      eps_l <= eps_l_n;
      sp_l  <= sp_l_n;
    end
  // character and status update with a single-cycle FIFO write strobe
  always_ff @(posedge clk)
    if (rst) begin
      push    <= 1'b0;
      rx_data <= 8'd0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      bi      <= 1'b0;
    end else begin
      push <= done;
      if (done) begin
        rx_data <= shreg;
        pe      <= pen_l & (pbit ^ exp_par);
        fe      <= ~rxs;
        bi      <= shreg == 8'd0 && !(pen_l && pbit) && !rxs;
      end
    end
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: directed frames against a frame-level receive model with per-push checking
module tb_uart_rx_top;
  logic       clk = 0, rst = 1, baud_pulse = 0, rx = 1;
  logic       sticky_parity = 0, eps = 0, pen = 0;
  logic [1:0] wls = 2'd3;
  logic [7:0] rx_data;
  logic       push, pe, fe, bi, rx_busy;
  typedef struct {logic [7:0] d; logic pe, fe, bi; int p0, lat;} exp_t;
  exp_t q[$];
  exp_t cx;
  int n_chk = 0, n_fail = 0, pn = 0, pushes = 0, last_lat = 0;
  logic [7:0] last_data;
  logic last_pe, last_fe, last_bi, push_d = 0;

  uart_rx_top dut (.clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx),
    .sticky_parity(sticky_parity), .eps(eps), .pen(pen), .wls(wls),
    .rx_data(rx_data), .push(push), .pe(pe), .fe(fe), .bi(bi), .rx_busy(rx_busy));

  always #5 clk = ~clk;

  initial forever begin
    repeat (5) @(posedge clk);
    #1 baud_pulse = 1;
    @(posedge clk);
    #1 baud_pulse = 0;
  end

  always @(posedge clk) if (baud_pulse) pn <= pn + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (push) begin
      pushes++;
      if (q.size() == 0) chk("spurious_push", 1, 0);
      else begin
        cx = q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, cx.d});
        chk("pe", {31'd0, pe}, {31'd0, cx.pe});
        chk("fe", {31'd0, fe}, {31'd0, cx.fe});
        chk("bi", {31'd0, bi}, {31'd0, cx.bi});
        chk("latency", pn - cx.p0, cx.lat);
        last_lat = pn - cx.p0;
      end
      last_data = rx_data;
      last_pe = pe;
      last_fe = fe;
      last_bi = bi;
    end
    if (push && push_d) chk("push_width", 2, 1);
    push_d = push;
  end

  task automatic wait_pulses(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_pulse) @(posedge clk);
    end
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int nb, input logic p_en, input logic e,
                      input logic s, input logic pb, input bit scr);
    exp_t x;
    logic [7:0] m;
    int ones;
    m = 8'((1 << nb) - 1);
    ones = $countones(d & m) + int'(pb);
    x.d = d & m;
    x.pe = p_en && (s ? (pb != !e) : ((ones % 2) != (e ? 0 : 1)));
    x.fe = 0;
    x.bi = 0;
    x.lat = 8 + 16 * (nb + int'(p_en)) + 16;
    wls = 2'(nb - 5);
    pen = p_en;
    eps = e;
    sticky_parity = s;
    rx = 0;
    x.p0 = pn + 1;
    q.push_back(x);
    wait_pulses(16);
    if (scr) begin
      wls = ~wls;
      pen = ~pen;
      eps = ~eps;
      sticky_parity = ~sticky_parity;
    end
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      wait_pulses(16);
    end
    if (p_en) begin
      rx = pb;
      wait_pulses(16);
    end
    rx = 1;
    wait_pulses(36);
  endtask

  initial begin
    exp_t b;
    int pc;
    logic [7:0] v;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    chk("reset_rx_data", {24'd0, rx_data}, 0);
    chk("reset_push", {31'd0, push}, 0);
    chk("reset_status", {29'd0, pe, fe, bi}, 0);
    chk("reset_busy", {31'd0, rx_busy}, 0);
    wait_pulses(20);

    send(8'hA5, 8, 1, 1, 0, 0, 0);
    chk("t1_data", {24'd0, last_data}, 32'hA5);
    chk("t1_pe", {31'd0, last_pe}, 0);
    chk("t1_fe_bi", {30'd0, last_fe, last_bi}, 0);

    send(8'hA5, 8, 1, 1, 0, 1, 0);
    chk("t2a_data", {24'd0, last_data}, 32'hA5);
    chk("t2a_pe", {31'd0, last_pe}, 1);
    send(8'hA5, 8, 1, 0, 1, 1, 0);
    chk("t2b_pe", {31'd0, last_pe}, 0);

    send(8'h16, 5, 0, 0, 0, 0, 0);
    chk("t3_data", {24'd0, last_data}, 32'h16);
    chk("t3_latency", last_lat, 104);

    pc = pushes;
    wls = 2'd3;
    pen = 0;
    rx = 0;
    wait_pulses(4);
    chk("t4_busy_glitch", {31'd0, rx_busy}, 1);
    rx = 1;
    wait_pulses(12);
    chk("t4_busy_after", {31'd0, rx_busy}, 0);
    chk("t4_no_push", pushes - pc, 0);
    send(8'h3C, 8, 0, 0, 0, 0, 0);
    chk("t4_data", {24'd0, last_data}, 32'h3C);

    pc = pushes;
    wls = 2'd3;
    pen = 0;
    b.d = 0;
    b.pe = 0;
    b.fe = 1;
    b.bi = 1;
    b.lat = 152;
    rx = 0;
    b.p0 = pn + 1;
    q.push_back(b);
    wait_pulses(480);
    chk("t5_one_push", pushes - pc, 1);
    chk("t5_busy_brk", {31'd0, rx_busy}, 1);
    rx = 1;
    wait_pulses(40);
    chk("t5_busy_idle", {31'd0, rx_busy}, 0);
    chk("t5_still_one", pushes - pc, 1);
    chk("t5_status", {24'd0, last_data, last_fe, last_bi}, 32'h3);
    send(8'h55, 8, 1, 0, 0, 0, 0);
    chk("t5_next_data", {24'd0, last_data}, 32'h55);
    chk("t5_next_pe", {31'd0, last_pe}, 1);

    pc = pushes;
    wls = 2'd3;
    pen = 0;
    v = 8'h5A;
    rx = 0;
    wait_pulses(16);
    for (int i = 0; i < 3; i++) begin
      rx = v[i];
      wait_pulses(16);
    end
    rx = v[3];
    wait_pulses(8);
    chk("t6_busy_mid", {31'd0, rx_busy}, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("t6_rst_outputs", {22'd0, rx_data, push, pe, fe, bi, rx_busy}, 0);
    rx = 1;
    wait_pulses(200);
    chk("t6_no_push", pushes - pc, 0);
    send(8'h81, 8, 0, 0, 0, 0, 1);
    chk("t6_data", {24'd0, last_data}, 32'h81);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

16550-style UART receiver, the receive-side counterpart of `uart_tx_top`. It oversamples the serial `rx` line at 16× using the shared `baud_pulse` tick, and recovers frames in the format set by the LCR fields `wls`, `pen`, `eps` and `sticky_parity`. Each received character is pushed into the RX FIFO together with its parity-error, framing-error and break status.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `baud_pulse` in 1: one-`clk`-wide tick at 16× the bit rate. All receiver activity advances only on cycles where it is high.
- `rx` in 1: serial input. Idles high.
- `sticky_parity` in 1: LCR stick parity.
- `eps` in 1: LCR even parity select.
- `pen` in 1: LCR parity enable.
- `wls` in 2: LCR word length. Data bits = 5 + `wls`.
- `rx_data` out 8: received character, LSB = first bit. Unused upper bits are 0.
- `push` out 1: one-cycle write strobe to the RX FIFO.
- `pe` out 1: parity error for `rx_data`.
- `fe` out 1: framing error for `rx_data`.
- `bi` out 1: break indication for `rx_data`.
- `rx_busy` out 1: high in every state except IDLE.

## Operation
Let `rxs` be the sampled line (`rx` directly, or after the synchronizer; see Configuration). `cnt` is a 4-bit counter of baud pulses.

State machine (transitions only on `baud_pulse`):
- **IDLE**: if `rxs`==0, go to START with `cnt`=0.
- **START**: increment `cnt`. When `cnt`==7 (mid start bit):
  - if `rxs`==0, latch `wls`/`pen`/`eps`/`sticky_parity`, set `cnt`=0, clear the bit index, go to DATA;
  - otherwise go to IDLE (glitch rejected, no push).
- **DATA**: when `cnt`==15, shift `rxs` into `shreg` at the bit index. After bit 4+`wls_l`, go to PARITY if `pen_l`, else STOP.
- **PARITY**: when `cnt`==15, capture the parity bit `pbit`, then go to STOP.
- **STOP**: when `cnt`==15, sample the stop bit, update outputs, pulse `push`. If the stop bit is 0, go to BRK_WAIT; else go to IDLE.
- **BRK_WAIT**: stay until `rxs`==1, then go to IDLE.

Status rules:
- Expected parity, selected by `sticky_parity_l`,`eps_l`:
  - 00: odd, expected = ~^data
  - 01: even, expected = ^data
  - 10: expected = 1
  - 11: expected = 0
- `pe` = `pen_l` && (`pbit` != expected).
- `fe` = (stop sample == 0).
- `bi` = every data bit 0, `pbit` 0 (when `pen_l`), and stop bit 0.
- `stb` is not an input. Only the first stop bit is checked. A new start is searched from the mid-stop point onward.
- LCR changes mid-frame have no effect until the next confirmed start bit.

## Timing
- Reset values: `rx_data`=0, `push`=0, `pe`=0, `fe`=0, `bi`=0, `rx_busy`=0, state IDLE, `cnt`=0.
- `rst` mid-frame aborts immediately with no push. The next frame is detected normally.
- `push` goes high in the cycle after the `clk` edge on which the stop sample is taken, for exactly one cycle, even if `baud_pulse` is high again.
- `rx_data`/`pe`/`fe`/`bi` update on the same edge that raises `push`, and hold until the next push.
- Start edge to `push`: 8 + 16·(5+`wls`+`pen`) + 16 baud pulses, plus the synchronizer delay when enabled.
- The FIFO has no backpressure. Overrun is the FIFO's responsibility.

## Configuration
- `UART_RX_SYNC_EN` defined: `rx` passes through a two-flop synchronizer (reset to 1) clocked every `clk`. `rxs` lags `rx` by 2 `clk` cycles.
- `UART_RX_SYNC_EN` undefined: `rxs` = `rx` combinationally. The input must already be synchronous to `clk`.

## Test plan
Bench: `baud_pulse` every 6 `clk` cycles; each bit is 16 pulses.

1. `wls`=11, `pen`=1, `eps`=1, `sticky_parity`=0; send 0xA5 with parity 0 and stop 1 → one `push`, `rx_data`=0xA5, `pe`=0, `fe`=0, `bi`=0.
2. Same as 1 but with parity bit 1 → `rx_data`=0xA5, `pe`=1. With `sticky_parity`=1, `eps`=0 and parity bit 1 → `pe`=0.
3. `wls`=00, `pen`=0; send 5'b10110 → `rx_data`=0x16, no parity slot, `push` 8+96 pulses after the start edge.
4. Low glitch of 4 baud pulses on idle `rx` → no `push`, `rx_busy` returns to 0, and a following 0x3C frame is received correctly.
5. Hold `rx` low for 3 frame times, then high → exactly one `push` with `rx_data`=0, `fe`=1, `bi`=1. No further push until `rx` has been high and a new start arrives.
6. Assert `rst` for 1 cycle during data bit 3 → all outputs 0, no `push`. A fresh 0x81 frame afterwards → `rx_data`=0x81.
